// File: rtl/noc_pkg.sv
// Shared flit format for the mesh NoC: field positions, decode, parity and a
// saturating counter helper.
package noc_pkg;

  localparam int FLIT_W         = 32;
  localparam int FLIT_VALID_BIT = 31;
  localparam int DST_ROW_LSB    = 29;
  localparam int DST_COL_LSB    = 27;
  localparam int SRC_ROW_LSB    = 25;
  localparam int SRC_COL_LSB    = 23;
  localparam int K_LSB          = 19;
  localparam int A_LSB          = 11;
  localparam int B_LSB          = 3;
  localparam int RSVD_LSB       = 1;
  localparam int PARITY_BIT     = 0;
  localparam int PAYLOAD_W      = 24;

  typedef struct packed {
    logic       valid;
    logic [1:0] dst_row;
    logic [1:0] dst_col;
    logic [1:0] src_row;
    logic [1:0] src_col;
    logic [3:0] k;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] rsvd;
    logic       parity;
  } flit_t;

  function automatic flit_t flit_decode(input logic [FLIT_W-1:0] raw);
    flit_t f;
    f.valid   = raw[FLIT_VALID_BIT];
    f.dst_row = raw[DST_ROW_LSB +: 2];
    f.dst_col = raw[DST_COL_LSB +: 2];
    f.src_row = raw[SRC_ROW_LSB +: 2];
    f.src_col = raw[SRC_COL_LSB +: 2];
    f.k       = raw[K_LSB +: 4];
    f.a       = raw[A_LSB +: 8];
    f.b       = raw[B_LSB +: 8];
    f.rsvd    = raw[RSVD_LSB +: 2];
    f.parity  = raw[PARITY_BIT];
    return f;
  endfunction

  // Even parity over the whole flit, parity bit included.
  function automatic logic parity_ok(input logic [FLIT_W-1:0] raw);
    return ~^raw;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] flit_payload(input flit_t f);
    return {f.src_row, f.src_col, f.k, f.a, f.b};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Show-ahead circular FIFO with one extra pointer bit to tell full from empty.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same edge, so a full FIFO may still push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/noc_eject_ni.sv
// Ejection network interface: captures flits from the router local port, drops
// corrupt or misrouted ones, and queues the rest for the local PE.
module noc_eject_ni
  import noc_pkg::*;
#(
  parameter int         BUS_WIDTH = 32,
  parameter int         DEPTH     = 4,
  parameter logic [1:0] MY_ROW    = 2'd0,
  parameter logic [1:0] MY_COL    = 2'd0
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] router_out,
  output logic                 buffer_out,
  output logic                 pe_valid,
  input  logic                 pe_ready,
  output logic [7:0]           pe_a,
  output logic [7:0]           pe_b,
  output logic [3:0]           pe_k,
  output logic [1:0]           pe_src_row,
  output logic [1:0]           pe_src_col,
  output logic [7:0]           err_route,
  output logic [7:0]           err_parity,
  output logic [7:0]           err_ovf
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW+1:0]   DEPTH_W = (AW+2)'(DEPTH);

  logic [BUS_WIDTH-1:0] stage_q, stage_d;
  logic                 stage_v_q, stage_v_d;
  logic [7:0]           err_route_q, err_route_d;
  logic [7:0]           err_parity_q, err_parity_d;
  logic [7:0]           err_ovf_q, err_ovf_d;

  flit_t                stage_f;
  logic                 unused_stage_bits;
  logic                 flit_in;
  logic                 capture;
  logic                 overflow;
  logic                 parity_bad;
  logic                 route_bad;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [AW:0]          fifo_count;
  logic [AW+1:0]        occupancy;
  logic [PAYLOAD_W-1:0] head;

  assign stage_f           = flit_decode(stage_q);
  assign unused_stage_bits = &{1'b0, stage_f.valid, stage_f.rsvd, stage_f.parity};

  // The staged flit is counted as occupied, so it always has a FIFO slot waiting.
  assign occupancy  = {1'b0, fifo_count} + {{(AW+1){1'b0}}, stage_v_q};
  assign buffer_out = (occupancy >= DEPTH_W);

  assign flit_in  = router_out[FLIT_VALID_BIT];
  assign capture  = flit_in && !buffer_out;
  assign overflow = flit_in && buffer_out;

  assign parity_bad = stage_v_q && !parity_ok(stage_q);
  assign route_bad  = stage_v_q && !parity_bad &&
                      ({stage_f.dst_row, stage_f.dst_col} != {MY_ROW, MY_COL});
  assign fifo_push  = stage_v_q && !parity_bad && !route_bad;
  assign fifo_pop   = pe_valid && pe_ready;

  always_comb begin
    stage_d      = stage_q;
    stage_v_d    = capture;
    err_route_d  = err_route_q;
    err_parity_d = err_parity_q;
    err_ovf_d    = err_ovf_q;
    if (capture) begin
      stage_d = router_out;
    end
    if (parity_bad) begin
      err_parity_d = sat_inc(err_parity_q);
    end
    if (route_bad) begin
      err_route_d = sat_inc(err_route_q);
    end
    if (overflow) begin
      err_ovf_d = sat_inc(err_ovf_q);
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      stage_q      <= '0;
      stage_v_q    <= 1'b0;
      err_route_q  <= '0;
      err_parity_q <= '0;
      err_ovf_q    <= '0;
    end else begin
      stage_q      <= stage_d;
      stage_v_q    <= stage_v_d;
      err_route_q  <= err_route_d;
      err_parity_q <= err_parity_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  noc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk   (clk1),
    .rst_n (rst),
    .push  (fifo_push),
    .wdata (flit_payload(stage_f)),
    .pop   (fifo_pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pe_valid = !fifo_empty;
  assign {pe_src_row, pe_src_col, pe_k, pe_a, pe_b} = head;

  assign err_route  = err_route_q;
  assign err_parity = err_parity_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_noc_eject_ni.sv
// Randomised scoreboard bench for noc_eject_ni at node (1,2) with a 4-deep FIFO.
module tb_noc_eject_ni;

  localparam int         DEPTH  = 4;
  localparam logic [1:0] MY_ROW = 2'd1;
  localparam logic [1:0] MY_COL = 2'd2;
  localparam logic [31:0] GOOD  = 32'hB1A9E538;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [31:0] router_out;
  logic        buffer_out;
  logic        pe_valid;
  logic        pe_ready;
  logic [7:0]  pe_a, pe_b;
  logic [3:0]  pe_k;
  logic [1:0]  pe_src_row, pe_src_col;
  logic [7:0]  err_route, err_parity, err_ovf;

  always #5 clk1 = ~clk1;

  noc_eject_ni #(
    .BUS_WIDTH (32),
    .DEPTH     (DEPTH),
    .MY_ROW    (MY_ROW),
    .MY_COL    (MY_COL)
  ) dut (
    .clk1       (clk1),
    .rst        (rst),
    .router_out (router_out),
    .buffer_out (buffer_out),
    .pe_valid   (pe_valid),
    .pe_ready   (pe_ready),
    .pe_a       (pe_a),
    .pe_b       (pe_b),
    .pe_k       (pe_k),
    .pe_src_row (pe_src_row),
    .pe_src_col (pe_src_col),
    .err_route  (err_route),
    .err_parity (err_parity),
    .err_ovf    (err_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: delivered payloads in arrival order, one staged flit, error tallies.
  logic [23:0] model_fifo[$];
  logic [23:0] sb_q[$];
  logic        model_stage_v;
  logic [31:0] model_stage;
  int          m_route, m_par, m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] make_flit(input logic [1:0] dr, input logic [1:0] dc,
                                            input logic [1:0] sr, input logic [1:0] sc,
                                            input logic [3:0] k, input logic [7:0] a,
                                            input logic [7:0] b, input bit corrupt);
    logic [31:0] f;
    f    = {1'b1, dr, dc, sr, sc, k, a, b, 2'b00, 1'b0};
    f[0] = (^f[31:1]) ^ corrupt;
    return f;
  endfunction

  function automatic logic [31:0] rand_flit(input int kind);
    logic [1:0] dr, dc;
    logic [31:0] r;
    dr = 2'($urandom_range(0, 3));
    dc = 2'($urandom_range(0, 3));
    case (kind)
      0: begin
        r = $urandom;
        r[31] = 1'b0;
        return r;
      end
      1: return make_flit(MY_ROW, MY_COL, 2'($urandom), 2'($urandom), 4'($urandom),
                          8'($urandom), 8'($urandom), 1'b0);
      2: return make_flit(dr, dc, 2'($urandom), 2'($urandom), 4'($urandom),
                          8'($urandom), 8'($urandom), 1'b1);
      default: begin
        if (dr == MY_ROW && dc == MY_COL) dc = 2'd3;
        return make_flit(dr, dc, 2'($urandom), 2'($urandom), 4'($urandom),
                         8'($urandom), 8'($urandom), 1'b0);
      end
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Advances the model across one clock edge with the given inputs.
  task automatic modelStep(input logic [31:0] flit, input logic ready);
    bit          full;
    bit          do_push;
    logic [23:0] item;
    full    = (model_fifo.size() + int'(model_stage_v)) >= DEPTH;
    do_push = 1'b0;
    item    = '0;
    if (model_stage_v) begin
      if (^model_stage) m_par = sat(m_par);
      else if (model_stage[30:27] != {MY_ROW, MY_COL}) m_route = sat(m_route);
      else begin
        do_push = 1'b1;
        item    = model_stage[26:3];
      end
    end
    if (ready && model_fifo.size() > 0) void'(model_fifo.pop_front());
    if (do_push) begin
      model_fifo.push_back(item);
      sb_q.push_back(item);
    end
    model_stage_v = 1'b0;
    if (flit[31]) begin
      if (full) m_ovf = sat(m_ovf);
      else begin
        model_stage   = flit;
        model_stage_v = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    check("pe_valid", {31'd0, pe_valid}, {31'd0, model_fifo.size() != 0});
    check("buffer_out", {31'd0, buffer_out},
          {31'd0, (model_fifo.size() + int'(model_stage_v)) >= DEPTH});
    check("err_route", {24'd0, err_route}, m_route);
    check("err_parity", {24'd0, err_parity}, m_par);
    check("err_ovf", {24'd0, err_ovf}, m_ovf);
    if (model_fifo.size() != 0)
      check("pe_head", {8'd0, pe_src_row, pe_src_col, pe_k, pe_a, pe_b}, {8'd0, model_fifo[0]});
  endtask

  task automatic applyStimulus(input logic [31:0] flit, input logic ready);
    router_out = flit;
    pe_ready   = ready;
    @(posedge clk1);
    modelStep(flit, ready);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    router_out = '0;
    pe_ready   = 1'b0;
    @(negedge clk1);
    rst = 1'b0;
    #1;
    check("rst_pe_valid", {31'd0, pe_valid}, 32'd0);
    check("rst_buffer_out", {31'd0, buffer_out}, 32'd0);
    check("rst_errs", {8'd0, err_route, err_parity, err_ovf}, 32'd0);
    check("rst_pe_data", {8'd0, pe_src_row, pe_src_col, pe_k, pe_a, pe_b}, 32'd0);
    model_fifo.delete();
    sb_q.delete();
    model_stage_v = 1'b0;
    model_stage   = '0;
    m_route = 0;
    m_par   = 0;
    m_ovf   = 0;
    @(posedge clk1);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: every PE handshake must match the oldest expected delivery.
  initial begin
    forever begin
      @(negedge clk1);
      if (rst === 1'b1 && pe_valid === 1'b1 && pe_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL pe_transfer: got 0x%0h, expected no transfer",
                   {pe_src_row, pe_src_col, pe_k, pe_a, pe_b});
        end else begin
          check("pe_transfer", {8'd0, pe_src_row, pe_src_col, pe_k, pe_a, pe_b},
                {8'd0, sb_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    router_out = '0;
    pe_ready   = 1'b0;
    doReset();

    // Single good flit and its latency.
    applyStimulus(GOOD, 1'b1);
    check("latency_edge1", {31'd0, pe_valid}, 32'd0);
    applyStimulus(32'd0, 1'b1);
    check("latency_edge2", {31'd0, pe_valid}, 32'd1);
    check("single_data", {8'd0, pe_src_row, pe_src_col, pe_k, pe_a, pe_b},
          {8'd0, 2'd0, 2'd3, 4'h5, 8'h3C, 8'hA7});
    applyStimulus(32'd0, 1'b1);
    check("single_pulse", {31'd0, pe_valid}, 32'd0);

    // Parity and routing errors.
    applyStimulus(32'hB1A9E539, 1'b1);
    applyStimulus(32'hB9A9E539, 1'b1);
    applyStimulus(32'd0, 1'b1);
    applyStimulus(32'd0, 1'b1);
    check("err_parity_one", {24'd0, err_parity}, 32'd1);
    check("err_route_one", {24'd0, err_route}, 32'd1);
    check("err_no_valid", {31'd0, pe_valid}, 32'd0);

    // Backpressure: six back-to-back flits, two land while full.
    for (int i = 0; i < 6; i++) applyStimulus(rand_flit(1), 1'b0);
    check("bp_full", {31'd0, buffer_out}, 32'd1);
    check("bp_ovf", {24'd0, err_ovf}, 32'd2);
    for (int i = 0; i < 6; i++) applyStimulus(32'd0, 1'b1);
    check("bp_drained", {31'd0, buffer_out}, 32'd0);
    check("bp_all_delivered", sb_q.size(), 32'd0);

    // Full FIFO then continuous traffic with the PE draining (pointer wrap).
    for (int i = 0; i < 5; i++) applyStimulus(rand_flit(1), 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(rand_flit(1), 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(32'd0, 1'b1);

    // Random mix of idle, good, corrupt and misrouted flits with random PE stalls.
    for (int i = 0; i < 500; i++)
      applyStimulus(rand_flit($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));

    // Reset while flits are buffered and staged.
    for (int i = 0; i < 4; i++) applyStimulus(rand_flit(1), 1'b0);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(32'd0, 1'b1);
    check("post_reset_empty", {31'd0, pe_valid}, 32'd0);

    // Counter saturation.
    for (int i = 0; i < 300; i++) applyStimulus(rand_flit(3), 1'b1);
    applyStimulus(32'd0, 1'b1);
    check("sat_route", {24'd0, err_route}, 32'hFF);
    for (int i = 0; i < 5; i++) applyStimulus(rand_flit(3), 1'b1);
    applyStimulus(32'd0, 1'b1);
    check("sat_route_hold", {24'd0, err_route}, 32'hFF);
    doReset();
    check("sat_route_cleared", {24'd0, err_route}, 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(32'd0, 1'b1);
    check("final_sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
